// File: rtl/kmkz_pkg.sv
// rtl/kmkz_pkg.sv - shared owner encodings and constants for the memory arbiter
package kmkz_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  localparam logic [3:0] IF_BE = 4'hF;

  // Saturating increment of the consecutive-data-grant counter.
  function automatic logic [3:0] run_next(input logic [3:0] cnt, input logic [3:0] max_run);
    return (cnt == max_run) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/kamikaze_arb_pick.sv
// rtl/kamikaze_arb_pick.sv - combinational fairness rule choosing the next bus owner
module kamikaze_arb_pick
  import kmkz_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic       if_req_i,
  input  logic       if_flush_i,
  input  logic       d_req_i,
  input  logic [3:0] run_cnt_i,
  output logic [1:0] owner_o
);

  localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

  logic fetch_ok;

  // A flushed fetch address is stale, so it cannot win this cycle.
  always_comb begin
    fetch_ok = if_req_i && !if_flush_i;
    owner_o  = OWN_IDLE;
    if (fetch_ok && (!d_req_i || run_cnt_i == MAX_RUN)) begin
      owner_o = OWN_IF;
    end else if (d_req_i) begin
      owner_o = OWN_D;
    end
  end

endmodule

// File: rtl/kamikaze_mem_arbiter.sv
// rtl/kamikaze_mem_arbiter.sv - shares one memory port between instruction fetch and load/store
module kamikaze_mem_arbiter
  import kmkz_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [1:0]  owner_o
);

  localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

  owner_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic        drop_q, drop_d;
  logic [1:0]  pick;
  logic        pick_en;

  kamikaze_arb_pick #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_pick (
    .if_req_i  (if_req_i),
    .if_flush_i(if_flush_i),
    .d_req_i   (d_req_i),
    .run_cnt_i (run_cnt_q),
    .owner_o   (pick)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    run_cnt_d   = run_cnt_q;
    drop_d      = drop_q;
    pick_en     = (state_q == OWN_IDLE) || mem_ready_i;

    // A flush during a fetch lets the bus finish but hides the response.
    if (state_q == OWN_IF) begin
      if (mem_ready_i) begin
        drop_d = 1'b0;
      end else if (if_flush_i) begin
        drop_d = 1'b1;
      end
    end

    if (pick_en) begin
      case (pick)
        OWN_IF: begin
          state_d    = OWN_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_be_d   = IF_BE;
          mem_addr_d = if_addr_i;
          run_cnt_d  = 4'd0;
        end
        OWN_D: begin
          state_d     = OWN_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_be_d    = d_be_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          run_cnt_d   = if_req_i ? run_next(run_cnt_q, MAX_RUN) : 4'd0;
        end
        default: begin
          state_d   = OWN_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= OWN_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      run_cnt_q   <= 4'd0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      run_cnt_q   <= run_cnt_d;
      drop_q      <= drop_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign owner_o     = state_q;

  assign if_ready_o = mem_ready_i && (state_q == OWN_IF) && !drop_q && !if_flush_i;
  assign d_ready_o  = mem_ready_i && (state_q == OWN_D);
  assign if_rdata_o = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_kamikaze_mem_arbiter.sv
// tb/tb_kamikaze_mem_arbiter.sv - self-checking bench for the fetch/data memory arbiter
module tb_kamikaze_mem_arbiter;

  localparam int MAX = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, if_flush_i, d_req_i, d_we_i, mem_ready_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [3:0]  d_be_i;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ready_o, d_ready_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [1:0]  owner_o;

  logic       p_if_req, p_flush, p_d_req;
  logic [3:0] p_cnt;
  logic [1:0] p_owner;

  int errors = 0;
  int checks = 0;

  // Reference state: the transaction currently owning the bus (0 none, 1 fetch, 2 data).
  int          m_cur;
  logic [31:0] m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_be;
  bit          m_drop, m_zero;
  int          m_run;
  bit          d_pend;

  typedef struct {
    logic       if_req;
    logic       flush;
    logic       d_req;
    logic [3:0] cnt;
    logic [1:0] exp;
  } pick_vec_t;

  pick_vec_t pv[12];
  int        exp_seq[10];

  always #5 clk_i = ~clk_i;

  kamikaze_mem_arbiter #(.MAX_DATA_RUN(MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i), .owner_o(owner_o)
  );

  kamikaze_arb_pick #(.MAX_DATA_RUN(MAX)) u_pick_chk (
    .if_req_i(p_if_req), .if_flush_i(p_flush), .d_req_i(p_d_req),
    .run_cnt_i(p_cnt), .owner_o(p_owner)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_drop = 0; m_run = 0; m_zero = 1;
  endtask

  task automatic model_check();
    chk("mem_req", mem_req_o, m_cur != 0);
    chk("owner", owner_o, m_cur);
    chk("if_ready", if_ready_o, mem_ready_i && m_cur == 1 && !m_drop && !if_flush_i);
    chk("d_ready", d_ready_o, mem_ready_i && m_cur == 2);
    if (m_cur == 1 && mem_ready_i) chk("if_rdata", if_rdata_o, mem_rdata_i);
    if (m_cur == 2 && mem_ready_i) chk("d_rdata", d_rdata_o, mem_rdata_i);
    if (m_cur != 0) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we", mem_we_o, m_we);
      chk("mem_be", mem_be_o, m_be);
    end
    if (m_cur == 2) chk("mem_wdata", mem_wdata_o, m_wdata);
    if (m_cur == 0 && m_zero) begin
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_we", mem_we_o, 0);
      chk("rst_be", mem_be_o, 0);
      chk("rst_wdata", mem_wdata_o, 0);
    end
  endtask

  // Applies the arbitration rules to the inputs present just before the clock edge.
  task automatic model_step();
    bit want_if;
    if (!rst_i) begin
      model_reset();
      return;
    end
    if (m_cur == 1) begin
      if (mem_ready_i) m_drop = 0;
      else if (if_flush_i) m_drop = 1;
    end
    if (m_cur == 0 || mem_ready_i) begin
      want_if = if_req_i && !if_flush_i;
      if (want_if && (!d_req_i || m_run == MAX)) begin
        m_cur = 1; m_addr = if_addr_i; m_we = 0; m_be = 4'hF; m_run = 0; m_zero = 0;
      end else if (d_req_i) begin
        m_cur = 2; m_addr = d_addr_i; m_we = d_we_i; m_be = d_be_i; m_wdata = d_wdata_i;
        m_run = if_req_i ? ((m_run < MAX) ? m_run + 1 : MAX) : 0;
        m_zero = 0;
      end else begin
        m_cur = 0;
      end
    end
  endtask

  task automatic tick();
    #1;
    model_check();
    model_step();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_flush_i = 0; if_addr_i = 0;
    d_req_i = 0; d_we_i = 0; d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
    mem_ready_i = 0; mem_rdata_i = 0;
  endtask

  initial begin
    rst_i = 0;
    idle_inputs();
    model_reset();
    d_pend = 0;

    pv[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 2'd1};
    pv[1]  = '{1'b1, 1'b0, 1'b1, 4'd0, 2'd2};
    pv[2]  = '{1'b1, 1'b0, 1'b1, 4'd3, 2'd2};
    pv[3]  = '{1'b1, 1'b0, 1'b1, 4'd4, 2'd1};
    pv[4]  = '{1'b1, 1'b1, 1'b1, 4'd4, 2'd2};
    pv[5]  = '{1'b1, 1'b1, 1'b0, 4'd0, 2'd0};
    pv[6]  = '{1'b0, 1'b0, 1'b1, 4'd4, 2'd2};
    pv[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, 2'd0};
    pv[8]  = '{1'b0, 1'b1, 1'b0, 4'd0, 2'd0};
    pv[9]  = '{1'b1, 1'b0, 1'b1, 4'd2, 2'd2};
    pv[10] = '{1'b0, 1'b1, 1'b1, 4'd4, 2'd2};
    pv[11] = '{1'b1, 1'b0, 1'b0, 4'd4, 2'd1};
    for (int i = 0; i < 12; i++) begin
      p_if_req = pv[i].if_req; p_flush = pv[i].flush; p_d_req = pv[i].d_req; p_cnt = pv[i].cnt;
      #1;
      chk($sformatf("pick_vec%0d", i), p_owner, pv[i].exp);
    end

    @(negedge clk_i);
    tick(); tick();
    rst_i = 1;
    tick();

    // Fetch only, zero-wait memory
    if_req_i = 1; if_addr_i = 32'h100;
    #1; chk("t1_idle_req", mem_req_o, 0);
    tick();
    mem_ready_i = 1; if_addr_i = 32'h104;
    #1; chk("t1_req", mem_req_o, 1); chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_be", mem_be_o, 4'hF); chk("t1_ready", if_ready_o, 1);
    tick();
    if_req_i = 0;
    #1; chk("t1_nobubble", mem_req_o, 1); chk("t1_addr2", mem_addr_o, 32'h104);
    tick();
    mem_ready_i = 0;
    #1; chk("t1_done", mem_req_o, 0);
    tick();

    // Collision: data first, fetch right after
    if_req_i = 1; if_addr_i = 32'h300;
    d_req_i = 1; d_we_i = 1; d_be_i = 4'b0011; d_addr_i = 32'h2000; d_wdata_i = 32'hDEADBEEF;
    tick();
    mem_ready_i = 1; d_req_i = 0;
    #1; chk("t2_owner", owner_o, 2); chk("t2_we", mem_we_o, 1); chk("t2_be", mem_be_o, 4'b0011);
    chk("t2_wdata", mem_wdata_o, 32'hDEADBEEF); chk("t2_addr", mem_addr_o, 32'h2000);
    chk("t2_dready", d_ready_o, 1);
    tick();
    if_req_i = 0;
    #1; chk("t2_fetch_owner", owner_o, 1); chk("t2_fetch_addr", mem_addr_o, 32'h300);
    tick();
    idle_inputs();
    tick();

    // Starvation guard
    exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    if_req_i = 1; if_addr_i = 32'h500; d_req_i = 1; d_we_i = 0; d_be_i = 4'hF; d_addr_i = 32'h600;
    mem_ready_i = 1;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin d_req_i = 0; if_req_i = 0; end
      #1; chk($sformatf("t3_grant%0d", i), owner_o, exp_seq[i]);
      tick();
    end
    idle_inputs();
    tick();

    // Flush mid-fetch
    if_req_i = 1; if_addr_i = 32'h40;
    tick();
    #1; chk("t4_owner", owner_o, 1); chk("t4_addr", mem_addr_o, 32'h40);
    tick();
    if_flush_i = 1;
    tick();
    if_flush_i = 0; if_addr_i = 32'h80;
    tick();
    mem_ready_i = 1;
    #1; chk("t4_dropped", if_ready_o, 0);
    tick();
    if_req_i = 0;
    #1; chk("t4_new_addr", mem_addr_o, 32'h80); chk("t4_new_ready", if_ready_o, 1);
    tick();
    idle_inputs();
    tick();

    // Flush coincident with completion
    if_req_i = 1; if_addr_i = 32'h200;
    tick();
    mem_ready_i = 1; if_flush_i = 1; if_addr_i = 32'h204;
    #1; chk("t5_ready", if_ready_o, 0);
    tick();
    idle_inputs();
    #1; chk("t5_no_repick", mem_req_o, 0);
    tick();

    // Asynchronous reset mid-store
    d_req_i = 1; d_we_i = 1; d_be_i = 4'hF; d_addr_i = 32'h3000; d_wdata_i = 32'h12345678;
    tick();
    #1; chk("t6_owner", owner_o, 2);
    #2; rst_i = 0; model_reset();
    #1; chk("t6_req", mem_req_o, 0); chk("t6_own", owner_o, 0); chk("t6_addr", mem_addr_o, 0);
    chk("t6_wdata", mem_wdata_o, 0); chk("t6_be", mem_be_o, 0); chk("t6_we", mem_we_o, 0);
    @(negedge clk_i);
    tick();
    rst_i = 1; d_req_i = 0;
    tick();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h44;
    tick();
    mem_ready_i = 1; mem_rdata_i = 32'hCAFEF00D; d_req_i = 0;
    #1; chk("t6_load_addr", mem_addr_o, 32'h44); chk("t6_dready", d_ready_o, 1);
    chk("t6_rdata", d_rdata_o, 32'hCAFEF00D);
    tick();
    idle_inputs();
    tick();

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      if (!d_pend) begin
        d_req_i = ($urandom_range(0, 2) == 0);
        d_we_i = 1'($urandom_range(0, 1));
        d_be_i = 4'($urandom);
        d_addr_i = $urandom;
        d_wdata_i = $urandom;
        d_pend = d_req_i;
      end
      if_req_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) if_addr_i = $urandom & 32'hFFFF_FFFC;
      if_flush_i = ($urandom_range(0, 7) == 0);
      mem_ready_i = (m_cur != 0) && ($urandom_range(0, 2) != 0);
      mem_rdata_i = $urandom;
      if (m_cur == 2 && mem_ready_i) d_pend = 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
